// File: rtl/alu_seq_ctrl_pkg.sv
// Shared ALU op encodings and sequencer state type, used by both the ALU and alu_seq_ctrl.
package alu_seq_ctrl_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_ILL = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_WB
  } state_e;

  function automatic logic op_legal(input logic [1:0] op);
    return op != OP_ILL;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Operand-fetch / execute / writeback sequencer wrapped around an external combinational ALU.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic          use_carry,
  input  logic          src_acc,
  input  logic [DW-1:0] opnd_in,
  input  logic          opnd_valid,
  output logic          opnd_req,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_op,
  output logic          alu_c,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_cout,
  output logic [DW-1:0] acc,
  output logic          flag_c,
  output logic          flag_z,
  output logic          flag_n,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_e        state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, acc_q, acc_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          alu_c_q, alu_c_d, uc_q, uc_d, sa_q, sa_d;
  logic          fc_q, fc_d, fz_q, fz_d, fn_q, fn_d, err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = !op_legal(op) ? S_IDLE : (src_acc ? S_LOAD_B : S_LOAD_A);
      S_LOAD_A: if (opnd_valid) state_d = S_LOAD_B;
      S_LOAD_B: if (opnd_valid) state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    opnd_req = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    done     = (state_q == S_WB);
  end

  // Illegal ops touch nothing but the err pulse, so ALU outputs keep their last values.
  always_comb begin
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    alu_c_d  = alu_c_q;
    uc_d     = uc_q;
    sa_d     = sa_q;
    acc_d    = acc_q;
    fc_d     = fc_q;
    fz_d     = fz_q;
    fn_d     = fn_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        if (!op_legal(op)) err_d = 1'b1;
        else begin
          alu_op_d = op;
          uc_d     = use_carry;
          sa_d     = src_acc;
          if (src_acc) alu_a_d = acc_q;
        end
      end
      S_LOAD_A: if (opnd_valid) alu_a_d = opnd_in;
      S_LOAD_B: if (opnd_valid) begin
        alu_b_d = opnd_in;
        alu_c_d = uc_q & fc_q & (alu_op_q == OP_ADD);
      end
      S_WB: begin
        acc_d = alu_result;
        fz_d  = (alu_result == '0);
        fn_d  = alu_result[DW-1];
        if (alu_op_q == OP_ADD) fc_d = alu_cout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 2'b00;
      alu_c_q  <= 1'b0;
      uc_q     <= 1'b0;
      sa_q     <= 1'b0;
      acc_q    <= '0;
      fc_q     <= 1'b0;
      fz_q     <= 1'b0;
      fn_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      alu_c_q  <= alu_c_d;
      uc_q     <= uc_d;
      sa_q     <= sa_d;
      acc_q    <= acc_d;
      fc_q     <= fc_d;
      fz_q     <= fz_d;
      fn_q     <= fn_d;
      err_q    <= err_d;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  assign alu_c  = alu_c_q;
  assign acc    = acc_q;
  assign flag_c = fc_q;
  assign flag_z = fz_q;
  assign flag_n = fn_q;
  assign err    = err_q;

endmodule
